// File: rtl/mux_arb_n_pkg.sv
// Shared constants for mux_arb_n: mode encoding and the output data reset value.
package mux_arb_n_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Output data register resets to all copies of this bit, whatever WIDTH is.
  localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/mux_arb_n_rr_pick.sv
// Rotating-priority picker: first valid channel at or after i_ptr, wrapping modulo NUM.
// Purely combinational; the caller gates the result with its own load enable.
module mux_arb_n_rr_pick #(
  parameter int NUM   = 4,
  parameter int SEL_W = $clog2(NUM)
) (
  input  logic [NUM-1:0]   i_valid,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [NUM-1:0]   o_grant,
  output logic [SEL_W-1:0] o_idx
);

  logic [SEL_W:0]   w_sum;
  logic [SEL_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the channel at i_ptr is written last and wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (SEL_W + 1)'(k);
      if (w_sum >= (SEL_W + 1)'(NUM)) w_sum = w_sum - (SEL_W + 1)'(NUM);
      w_idx = w_sum[SEL_W-1:0];
      if (i_valid[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-input registered selector, explicit select or round-robin (RR only with MUX_ARB_RR_EN defined).
// Latency 1 cycle; 1 word/cycle; a stalled output (out_valid & !out_ready) blocks all in_ready.
module mux_arb_n
  import mux_arb_n_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NUM   = 4,
  localparam int SEL_W = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [NUM-1:0]       in_valid,
  output logic [NUM-1:0]       in_ready,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_src
);

  logic             w_load_en;
  logic [NUM-1:0]   w_sel_grant;
  logic [NUM-1:0]   w_grant;
  logic             w_any;
  logic [WIDTH-1:0] w_gdata;
  logic [SEL_W-1:0] w_gidx;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_src;
  logic             r_valid;

  // rst_n gates the load so nothing handshakes while reset is held.
  assign w_load_en = rst_n & (~r_valid | out_ready);

  always_comb begin
    w_sel_grant = '0;
    if (w_load_en && ({1'b0, sel} < (SEL_W + 1)'(NUM)) && in_valid[sel])
      w_sel_grant[sel] = 1'b1;
  end

`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0] r_ptr;
  logic [NUM-1:0]   w_rr_grant;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W-1:0] w_ptr_nxt;

  mux_arb_n_rr_pick #(.NUM(NUM), .SEL_W(SEL_W)) u_rr_pick (
    .i_valid (in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx)
  );

  assign w_grant   = (mode == MODE_RR) ? (w_rr_grant & {NUM{w_load_en}}) : w_sel_grant;
  assign w_ptr_nxt = (w_rr_idx == SEL_W'(NUM - 1)) ? '0 : w_rr_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else if ((mode == MODE_RR) && w_any) r_ptr <= w_ptr_nxt;
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_grant       = w_sel_grant;
`endif

  assign w_any    = |w_grant;
  assign in_ready = w_grant;

  always_comb begin
    w_gdata = '0;
    w_gidx  = '0;
    for (int i = 0; i < NUM; i++) begin
      if (w_grant[i]) begin
        w_gdata = in_data[i*WIDTH +: WIDTH];
        w_gidx  = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= {WIDTH{DATA_RST_BIT}};
      r_src   <= '0;
      r_valid <= 1'b0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_data  <= w_gdata;
        r_src   <= w_gidx;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n (NUM=4, WIDTH=32); RR cases only when MUX_ARB_RR_EN is defined.
module tb_mux_arb_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic         mode;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_src;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hA0A0_1111;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'hA0A0_3333;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(32), .NUM(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Settle combinational outputs after the negedge drive.
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [1:0] s, input logic m, input logic r);
    @(negedge clk);
    in_valid  = v;
    sel       = s;
    mode      = m;
    out_ready = r;
    settle();
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [31:0] d, input logic [1:0] src);
    check_val({tag, "_vld"}, {31'b0, out_valid}, {31'b0, vld});
    check_val({tag, "_dat"}, out_data, d);
    check_val({tag, "_src"}, {30'b0, out_src}, {30'b0, src});
  endtask

  initial begin
    in_data   = {D3, D2, D1, D0};
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    sel       = 2'd2;
    mode      = 1'b0;
    out_ready = 1'b1;

    repeat (3) tick();
    check_val("rst_rdy", {28'b0, in_ready}, 32'h0);
    check_out("rst", 1'b0, 32'h0, 2'd0);

    @(negedge clk);
    rst_n = 1'b1;
    settle();
    check_val("sel2_rdy", {28'b0, in_ready}, 32'h4);
    tick();
    check_out("sel2", 1'b1, D2, 2'd2);

    drive(4'hF, 2'd1, 1'b0, 1'b1);
    check_val("sel1_rdy", {28'b0, in_ready}, 32'h2);
    tick();
    check_out("sel1", 1'b1, D1, 2'd1);

    // Selected channel idle: output drains, data/src hold.
    drive(4'h7, 2'd3, 1'b0, 1'b1);
    check_val("idle_rdy", {28'b0, in_ready}, 32'h0);
    tick();
    check_out("idle", 1'b0, D1, 2'd1);

    // Load while empty even though out_ready is low.
    drive(4'hF, 2'd0, 1'b0, 1'b0);
    check_val("empty_rdy", {28'b0, in_ready}, 32'h1);
    tick();
    check_out("load0", 1'b1, D0, 2'd0);

    for (int c = 0; c < 3; c++) begin
      drive(4'hF, 2'd3, 1'b0, 1'b0);
      check_val("stall_rdy", {28'b0, in_ready}, 32'h0);
      tick();
      check_out("stall", 1'b1, D0, 2'd0);
    end

    drive(4'hF, 2'd3, 1'b0, 1'b1);
    check_val("resume_rdy", {28'b0, in_ready}, 32'h8);
    tick();
    check_out("resume", 1'b1, D3, 2'd3);

`ifdef MUX_ARB_RR_EN
    begin
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int k = 0; k < 5; k++) begin
        drive(4'hF, 2'd0, 1'b1, 1'b1);
        tick();
        check_val("rr_src", {30'b0, out_src}, {30'b0, exp_seq[k]});
      end
      // ptr is now 1: sparse channels 1 and 3 alternate.
      exp_seq = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd0};
      for (int k = 0; k < 3; k++) begin
        drive(4'hA, 2'd0, 1'b1, 1'b1);
        tick();
        check_val("rr_sparse", {30'b0, out_src}, {30'b0, exp_seq[k]});
      end
      drive(4'h0, 2'd0, 1'b1, 1'b1);
      check_val("rr_idle_rdy", {28'b0, in_ready}, 32'h0);
      tick();
      check_out("rr_idle", 1'b0, D1, 2'd1);
      // ptr is 2: explicit traffic must not move it.
      drive(4'hF, 2'd0, 1'b0, 1'b1);
      tick();
      drive(4'hF, 2'd0, 1'b1, 1'b1);
      check_val("rr_ptr_rdy", {28'b0, in_ready}, 32'h4);
      tick();
      check_out("rr_ptr", 1'b1, D2, 2'd2);
    end
`else
    drive(4'hF, 2'd1, 1'b1, 1'b1);
    check_val("nomac_rdy", {28'b0, in_ready}, 32'h2);
    tick();
    check_out("nomac", 1'b1, D1, 2'd1);
    drive(4'hD, 2'd1, 1'b1, 1'b1);
    check_val("nomac_idle_rdy", {28'b0, in_ready}, 32'h0);
    tick();
    check_out("nomac_idle", 1'b0, D1, 2'd1);
    drive(4'hF, 2'd2, 1'b1, 1'b1);
    tick();
`endif

    // Asynchronous reset with a word held discards it immediately.
    @(negedge clk);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    settle();
    check_val("arst_rdy", {28'b0, in_ready}, 32'h0);
    check_out("arst", 1'b0, 32'h0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
